// File: rtl/frame_sched_pkg.sv
// Shared definitions for the frame command scheduler: command-word field
// positions, action codes, FSM state type and small word-building helpers.
package frame_sched_pkg;

  localparam int CMD_W      = 32;
  localparam int COMP_MSB   = 31;
  localparam int COMP_LSB   = 26;
  localparam int CHILD_MSB  = 25;
  localparam int CHILD_LSB  = 21;
  localparam int ACT_MSB    = 20;
  localparam int ACT_LSB    = 17;
  localparam int TYPE_MSB   = 16;
  localparam int TYPE_LSB   = 14;
  localparam int TOGGLE_BIT = 13;
  localparam int DATA_MSB   = 12;
  localparam int DATA_LSB   = 0;

  localparam logic [3:0] ACT_NOP    = 4'h0;
  localparam logic [3:0] ACT_UPDATE = 4'h1;
  localparam logic [3:0] ACT_COMMIT = 4'hE;
  localparam logic [3:0] ACT_SWAP   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_WAIT_VBL,
    ST_SWAP
  } state_t;

  function automatic logic [3:0] cmd_action(input logic [CMD_W-1:0] word);
    return word[ACT_MSB:ACT_LSB];
  endfunction

  // Display blocks latch into the buffer named by the toggle bit, so every
  // forwarded word is retargeted at the buffer currently being built.
  function automatic logic [CMD_W-1:0] with_toggle(input logic [CMD_W-1:0] word,
                                                   input logic            buf_idx);
    logic [CMD_W-1:0] w;
    w             = word;
    w[TOGGLE_BIT] = buf_idx;
    return w;
  endfunction

  function automatic logic [CMD_W-1:0] swap_cmd(input logic buf_idx);
    logic [CMD_W-1:0] w;
    w                   = '0;
    w[ACT_MSB:ACT_LSB]  = ACT_SWAP;
    w[TOGGLE_BIT]       = buf_idx;
    return w;
  endfunction

endpackage

// File: rtl/frame_cmd_scheduler_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO; head always presents the oldest word.
// A pop and push in the same cycle are both honoured, even when full.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately left out of reset; an entry is
  // only ever read after it has been written, and the pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/frame_cmd_scheduler.sv
// Frame command scheduler: queues software commands, forwards them to the
// display blocks and swaps buffers at vblank. Optional: FRAME_SCHED_STATS_EN.
module frame_cmd_scheduler
  import frame_sched_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [9:0] VBLANK_LINE = 10'd480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avs_write,
  input  logic [CMD_W-1:0]  avs_writedata,
  output logic              avs_waitrequest,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic [CMD_W-1:0]  cmd_out,
  output logic              back_buf,
  output logic              frame_irq,
  output logic [15:0]       stat_late_frames
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [CMD_W-1:0]   fifo_head;
  logic               push;
  logic               pop;
  logic               vbl_trigger;

  assign avs_waitrequest = fifo_full;
  assign push            = avs_write && !fifo_full;
  assign pop             = (state == ST_DRAIN) && !fifo_empty;
  assign vbl_trigger     = (vcount == VBLANK_LINE) && (hcount == '0);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (avs_writedata),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cmd_out   <= '0;
      back_buf  <= 1'b1;
      frame_irq <= 1'b0;
    end else begin
      // NOTE: defaults first, so cmd_out returns to no-op and frame_irq is a
      // single-cycle pulse unless a branch below overrides them.
      cmd_out   <= '0;
      frame_irq <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (fifo_count != '0) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state <= ST_IDLE;
          end else if (cmd_action(fifo_head) == ACT_COMMIT) begin
            state <= ST_WAIT_VBL;
          end else begin
            cmd_out <= with_toggle(fifo_head, back_buf);
          end
        end
        ST_WAIT_VBL: begin
          // Trigger is an exact position match, so a COMMIT that lands after
          // this frame's trigger cycle naturally waits a whole frame.
          if (vbl_trigger) begin
            state   <= ST_SWAP;
            cmd_out <= swap_cmd(back_buf);
          end
        end
        ST_SWAP: begin
          state     <= ST_IDLE;
          back_buf  <= ~back_buf;
          frame_irq <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FRAME_SCHED_STATS_EN
  // A frame is late when vblank arrives while commands are still queued and
  // no COMMIT has been reached yet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_late_frames <= '0;
    end else if (vbl_trigger && !fifo_empty &&
                 (state == ST_IDLE || state == ST_DRAIN) &&
                 stat_late_frames != 16'hFFFF) begin
      stat_late_frames <= stat_late_frames + 16'd1;
    end
  end
`else
  assign stat_late_frames = 16'h0;
`endif

endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// Self-checking bench for frame_cmd_scheduler: queue-based frame model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_frame_cmd_scheduler;

  localparam int         DEPTH   = 16;
  localparam logic [9:0] VBL     = 10'd480;
  localparam logic [31:0] COMMIT = 32'h001C_0000;
  localparam logic [31:0] SWAP1  = 32'h001E_2000;
`ifdef FRAME_SCHED_STATS_EN
  localparam logic [15:0] LATE3 = 16'd3;
`else
  localparam logic [15:0] LATE3 = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [9:0]  hcount = 10'd5;
  logic [9:0]  vcount = 10'd0;
  logic        avs_waitrequest;
  logic [31:0] cmd_out;
  logic        back_buf;
  logic        frame_irq;
  logic [15:0] stat_late_frames;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  frame_cmd_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .VBLANK_LINE (VBL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_waitrequest  (avs_waitrequest),
    .hcount           (hcount),
    .vcount           (vcount),
    .cmd_out          (cmd_out),
    .back_buf         (back_buf),
    .frame_irq        (frame_irq),
    .stat_late_frames (stat_late_frames)
  );

  // Frame model: a queue of accepted words and a few flags describing where
  // the current frame is (being drained, committed and waiting, swapping).
  logic [31:0] q[$];
  bit          m_draining = 0;
  bit          m_armed    = 0;
  bit          m_swapping = 0;
  logic [31:0] m_cmd  = '0;
  logic        m_back = 1'b1;
  logic        m_irq  = 1'b0;
  logic [15:0] m_stat = '0;

  always @(posedge clk or negedge reset) begin
    bit          trig;
    bit          accept;
    logic [31:0] w;
    if (!reset) begin
      q.delete();
      m_draining = 0;
      m_armed    = 0;
      m_swapping = 0;
      m_cmd      = '0;
      m_back     = 1'b1;
      m_irq      = 1'b0;
      m_stat     = '0;
    end else begin
      trig   = (vcount == VBL) && (hcount == 10'd0);
      accept = avs_write && (q.size() < DEPTH);
`ifdef FRAME_SCHED_STATS_EN
      if (trig && !m_armed && !m_swapping && q.size() != 0 && m_stat != 16'hFFFF)
        m_stat = m_stat + 16'd1;
`endif
      m_cmd = '0;
      m_irq = 1'b0;
      if (m_swapping) begin
        m_swapping = 0;
        m_back     = ~m_back;
        m_irq      = 1'b1;
      end else if (m_armed) begin
        if (trig) begin
          m_armed    = 0;
          m_swapping = 1;
          m_cmd      = 32'h001E_0000 | (32'(m_back) << 13);
        end
      end else if (m_draining) begin
        if (q.size() == 0) begin
          m_draining = 0;
        end else begin
          w = q.pop_front();
          if (w[20:17] == 4'hE) begin
            m_draining = 0;
            m_armed    = 1;
          end else begin
            m_cmd = {w[31:14], m_back, w[12:0]};
          end
        end
      end else if (q.size() != 0) begin
        m_draining = 1;
      end
      if (accept) q.push_back(avs_writedata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("cmd_out",     cmd_out, m_cmd);
      check("back_buf",    32'(back_buf), 32'(m_back));
      check("frame_irq",   32'(frame_irq), 32'(m_irq));
      check("waitrequest", 32'(avs_waitrequest), 32'(q.size() == DEPTH));
      check("stat_late",   32'(stat_late_frames), 32'(m_stat));
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    int budget;
    budget        = 50;
    avs_write     = 1'b1;
    avs_writedata = w;
    while (avs_waitrequest && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("push_timeout", 32'(avs_waitrequest), 32'd0);
    tick();
    avs_write = 1'b0;
  endtask

  task automatic vblank();
    vcount = VBL;
    hcount = 10'd0;
    tick();
    vcount = 10'd0;
    hcount = 10'd5;
  endtask

  function automatic logic [31:0] upd(input logic [12:0] d);
    return 32'h0C22_0000 | 32'(d);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, n_bad %0d", n_bad);
    $fatal(1);
  end

  initial begin
    int budget;
    fork
      compare_loop();
    join_none

    // Reset state
    tick(3);
    check("rst_cmd_out",   cmd_out, 32'h0);
    check("rst_back_buf",  32'(back_buf), 32'd1);
    check("rst_irq",       32'(frame_irq), 32'd0);
    check("rst_waitreq",   32'(avs_waitrequest), 32'd0);
    check("rst_stat",      32'(stat_late_frames), 32'd0);
    reset = 1'b1;
    tick(2);

    // Three updates plus COMMIT, forwarded with toggle=1, then swap
    push(upd(13'h11));
    push(upd(13'h22));
    push(upd(13'h33));
    push(COMMIT);
    check("fwd_w1", cmd_out, 32'h0C22_2022);
    tick();
    check("fwd_w2", cmd_out, 32'h0C22_2033);
    tick();
    check("commit_hidden", cmd_out, 32'h0);
    vcount = VBL;
    hcount = 10'd1;
    tick(4);
    check("near_miss_cmd", cmd_out, 32'h0);
    hcount = 10'd0;
    tick();
    vcount = 10'd0;
    hcount = 10'd5;
    check("swap_word", cmd_out, SWAP1);
    check("swap_buf_hold", 32'(back_buf), 32'd1);
    tick();
    check("swap_buf_flip", 32'(back_buf), 32'd0);
    check("swap_irq", 32'(frame_irq), 32'd1);
    tick();
    check("irq_one_cycle", 32'(frame_irq), 32'd0);

    // Full FIFO while waiting for vblank
    push(COMMIT);
    tick(3);
    for (int i = 0; i < DEPTH; i++) push(upd(13'(i)));
    check("full_waitreq", 32'(avs_waitrequest), 32'd1);
    avs_write     = 1'b1;
    avs_writedata = upd(13'h17F);
    tick(3);
    check("held_waitreq", 32'(avs_waitrequest), 32'd1);
    vblank();
    budget = 20;
    while (avs_waitrequest && budget > 0) begin
      tick();
      budget--;
    end
    check("seventeenth_accept", 32'(avs_waitrequest), 32'd0);
    tick();
    avs_write = 1'b0;
    tick(25);
    check("after_full_buf", 32'(back_buf), 32'd1);

    // COMMIT popped after the trigger line waits for the next frame
    vcount = 10'd481;
    push(COMMIT);
    tick(3);
    vcount = 10'd482;
    tick(3);
    vcount = 10'd0;
    tick(3);
    vcount = VBL;
    hcount = 10'd3;
    tick(2);
    check("late_no_swap_cmd", cmd_out, 32'h0);
    check("late_no_swap_buf", 32'(back_buf), 32'd1);
    hcount = 10'd0;
    tick();
    vcount = 10'd0;
    hcount = 10'd5;
    check("late_swap_word", cmd_out, SWAP1);
    tick();
    check("late_swap_buf", 32'(back_buf), 32'd0);
    check("late_swap_irq", 32'(frame_irq), 32'd1);

    // Reset in the middle of draining a queued frame
    push(COMMIT);
    tick(3);
    for (int i = 0; i < 5; i++) push(upd(13'h50 + 13'(i)));
    push(COMMIT);
    vblank();
    tick(3);
    check("drain_first", cmd_out, 32'h0C22_2050);
    reset = 1'b0;
    #1;
    check("mid_rst_cmd",     cmd_out, 32'h0);
    check("mid_rst_waitreq", 32'(avs_waitrequest), 32'd0);
    check("mid_rst_buf",     32'(back_buf), 32'd1);
    tick(2);
    reset = 1'b1;
    tick(3);
    vblank();
    tick(4);
    check("no_swap_after_rst_buf", 32'(back_buf), 32'd1);
    check("no_swap_after_rst_cmd", cmd_out, 32'h0);

    // Late frames: vblank while a word is still queued without COMMIT
    for (int k = 0; k < 3; k++) begin
      push(upd(13'h60 + 13'(k)));
      vblank();
      tick(4);
    end
    check("late_frames", 32'(stat_late_frames), 32'(LATE3));

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
